sbn_dmem_arb: RTL and testbench

- Two-requester arbiter sharing the SBN machine's single-port data memory between the SBN core and a host/debug port. The host port is used for program data loading, inspection and result readback.
- Sits between the core's A/B/C data accesses and the dmem array.
- Grants one access per cycle, using round-robin priority.
- Supports a core lock so that the read A, read B, write C sequence of one SBN instruction executes atomically with respect to the host.

---
 rtl/sbn_arb_pkg.sv | 9 +
 rtl/sbn_rr2.sv | 20 ++
 rtl/sbn_dmem_arb.sv | 85 ++++++++
 tb/tb_sbn_dmem_arb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sbn_arb_pkg.sv
// sbn_arb_pkg: state/owner encodings, counter width and saturating increment for the SBN dmem arbiter
package sbn_arb_pkg;
  localparam int STATW = 16;
  typedef enum logic {FREE = 1'b0, CLOCKED = 1'b1} state_e;
  typedef enum logic [1:0] {NONE = 2'd0, CORE = 2'd1, HOST = 2'd2} owner_e;
  function automatic logic [STATW-1:0] sat_inc(input logic [STATW-1:0] v, input logic en);
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction
endpackage

// File: rtl/sbn_rr2.sv
// sbn_rr2: 2-way round-robin grant (core/host) with pointer, force-core and host-mask inputs
module sbn_rr2 (
  input  logic clk,
  input  logic rst_n,
  input  logic c_req,
  input  logic h_req,
  input  logic force_core,
  input  logic host_mask,
  output logic c_gnt,
  output logic h_gnt
);
  logic hpri_q, hpri_d, h_ok;
  always_comb begin
    h_ok   = h_req & ~host_mask;
    c_gnt  = c_req & (force_core | ~h_ok | ~hpri_q);
    h_gnt  = h_ok & ~c_gnt;
    hpri_d = c_gnt ? 1'b1 : h_gnt ? 1'b0 : hpri_q;
  end
  always_ff @(posedge clk) hpri_q <= rst_n ? hpri_d : 1'b0;
endmodule

// File: rtl/sbn_dmem_arb.sv
// sbn_dmem_arb: core/host dmem arbiter with core lock and 1-cycle read tagging; SBN_DMEM_ARB_STATS_EN adds stat_cgnt/stat_hgnt/stat_hstall
module sbn_dmem_arb import sbn_arb_pkg::*; #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [AW-1:0]    c_addr,
  input  logic [DW-1:0]    c_wdata,
  input  logic             c_lock,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic [DW-1:0]    c_rdata,
  input  logic             h_req,
  input  logic             h_we,
  input  logic [AW-1:0]    h_addr,
  input  logic [DW-1:0]    h_wdata,
  output logic             h_gnt,
  output logic             h_rvalid,
  output logic [DW-1:0]    h_rdata,
  output logic             m_en,
  output logic             m_we,
  output logic [AW-1:0]    m_addr,
  output logic [DW-1:0]    m_wdata,
  input  logic [DW-1:0]    m_rdata,
  output logic             locked
`ifdef SBN_DMEM_ARB_STATS_EN
  ,
  output logic [STATW-1:0] stat_cgnt,
  output logic [STATW-1:0] stat_hgnt,
  output logic [STATW-1:0] stat_hstall
`endif
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   lk;
  assign lk = state_q == CLOCKED;
  sbn_rr2 u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .c_req      (c_req & rst_n),
    .h_req      (h_req & rst_n),
    .force_core (lk),
    .host_mask  (lk),
    .c_gnt      (c_gnt),
    .h_gnt      (h_gnt)
  );
  always_comb begin
    m_en     = c_gnt | h_gnt;
    m_we     = c_gnt ? c_we : h_gnt & h_we;
    m_addr   = c_gnt ? c_addr : h_gnt ? h_addr : '0;
    m_wdata  = c_gnt ? c_wdata : h_gnt ? h_wdata : '0;
    state_d  = c_gnt ? (c_lock ? CLOCKED : FREE) : state_q;
    owner_d  = (c_gnt & ~c_we) ? CORE : (h_gnt & ~h_we) ? HOST : NONE;
    locked   = rst_n & lk;
    c_rvalid = rst_n & (owner_q == CORE);
    h_rvalid = rst_n & (owner_q == HOST);
    c_rdata  = m_rdata;
    h_rdata  = m_rdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FREE;
      owner_q <= NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`ifdef SBN_DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cgnt   <= '0;
      stat_hgnt   <= '0;
      stat_hstall <= '0;
    end else begin
      stat_cgnt   <= sat_inc(stat_cgnt, c_gnt);
      stat_hgnt   <= sat_inc(stat_hgnt, h_gnt);
      stat_hstall <= sat_inc(stat_hstall, h_req & ~h_gnt);
    end
  end
`endif
endmodule

// File: tb/tb_sbn_dmem_arb.sv
// tb_sbn_dmem_arb: randomized and directed scoreboard bench for sbn_dmem_arb against a rule-level model
module tb_sbn_dmem_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
  logic [7:0]  c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic        h_req = 1'b0, h_we = 1'b0;
  logic [7:0]  h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid, m_en, m_we, locked;
  logic [31:0] c_rdata, h_rdata, m_wdata;
  logic [31:0] m_rdata = '0;
  logic [7:0]  m_addr;
`ifdef SBN_DMEM_ARB_STATS_EN
  logic [15:0] stat_cgnt, stat_hgnt, stat_hstall;
`endif
  sbn_dmem_arb #(.AW(8), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_lock(c_lock),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .locked(locked)
`ifdef SBN_DMEM_ARB_STATS_EN
    , .stat_cgnt(stat_cgnt), .stat_hgnt(stat_hgnt), .stat_hstall(stat_hstall)
`endif
  );
  always #5 clk = ~clk;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    if (m_en && !m_we) m_rdata <= mem[m_addr];
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  typedef struct {logic [31:0] d; int c;} rd_t;
  rd_t cq[$], hq[$];
  always @(negedge clk) begin
    if (cq.size() != 0 && cq[0].c + 1 == cyc) begin
      chk("c_rvalid", c_rvalid, 1);
      chk("c_rdata", c_rdata, cq[0].d);
      cq.delete(0);
    end else if (c_rvalid) chk("c_rvalid_spurious", c_rvalid, 0);
    if (hq.size() != 0 && hq[0].c + 1 == cyc) begin
      chk("h_rvalid", h_rvalid, 1);
      chk("h_rdata", h_rdata, hq[0].d);
      hq.delete(0);
    end else if (h_rvalid) chk("h_rvalid_spurious", h_rvalid, 0);
  end
  logic m_lk = 1'b0, m_last_host = 1'b1, g_c, g_h;
  task automatic do_reset();
    rst_n = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_lock = 1'b0;
    h_req = 1'b1; h_we = 1'b1;
    cq.delete();
    hq.delete();
    @(negedge clk);
    chk("rst_gnt", {c_gnt, h_gnt}, 2'b00);
    chk("rst_m_en", m_en, 0);
    chk("rst_locked", locked, 0);
    chk("rst_rvalid", {c_rvalid, h_rvalid}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_lk = 1'b0;
    m_last_host = 1'b1;
  endtask
  task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                      input logic cl, input logic hr, input logic hw, input logic [7:0] ha,
                      input logic [31:0] hd);
    logic ecg, ehg;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd; c_lock = cl;
    h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
    @(negedge clk);
    ecg = m_lk ? cr : (cr && hr) ? m_last_host : cr;
    ehg = m_lk ? 1'b0 : (cr && hr) ? !m_last_host : hr;
    chk("grant", {c_gnt, h_gnt}, {ecg, ehg});
    chk("locked", locked, m_lk);
    chk("m_en", m_en, ecg | ehg);
    chk("m_bus", {m_we, m_addr, m_wdata}, ecg ? {cw, ca, cd} : ehg ? {hw, ha, hd} : 41'd0);
    if (ecg) begin
      m_last_host = 1'b0;
      m_lk = cl;
      if (cw) ref_mem[ca] = cd;
      else cq.push_back('{ref_mem[ca], cyc});
    end
    if (ehg) begin
      m_last_host = 1'b1;
      if (hw) ref_mem[ha] = hd;
      else hq.push_back('{ref_mem[ha], cyc});
    end
    g_c = ecg;
    g_h = ehg;
    @(posedge clk); #1;
  endtask
  logic rc_p = 0, rc_w = 0, rc_l = 0, rh_p = 0, rh_w = 0;
  logic [7:0] rc_a = 0, rh_a = 0;
  logic [31:0] rc_d = 0, rh_d = 0;
  int rc_s = 0;
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h1000 + i;
      ref_mem[i] = 32'h1000 + i;
    end
    do_reset();
    step(0, 0, 0, 0, 0, 1, 1, 8'h10, 32'h2a);
    step(0, 0, 0, 0, 0, 1, 0, 8'h10, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("host_readback_model", ref_mem[8'h10], 32'h2a);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'h30, 0, 0, 1, 0, 8'h31, 0);
      chk("alternate", {g_c, g_h}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
`ifdef SBN_DMEM_ARB_STATS_EN
    chk("stat_cgnt8", stat_cgnt, 4);
    chk("stat_hgnt8", stat_hgnt, 4);
`endif
    do_reset();
    step(1, 0, 8'h01, 0, 1, 1, 0, 8'h20, 0);
    step(1, 0, 8'h02, 0, 1, 1, 0, 8'h20, 0);
    step(1, 1, 8'h03, 32'h55, 0, 1, 0, 8'h20, 0);
    step(0, 0, 0, 0, 0, 1, 0, 8'h20, 0);
    chk("host_after_unlock", g_h, 1);
    step(0, 0, 0, 0, 0, 1, 1, 8'h04, 32'd5);
    step(0, 0, 0, 0, 0, 1, 1, 8'h05, 32'd7);
    step(1, 0, 8'h04, 0, 1, 0, 0, 0, 0);
    step(1, 0, 8'h05, 0, 1, 1, 0, 8'h06, 0);
    step(1, 1, 8'h06, 32'd5 - 32'd7, 0, 1, 0, 8'h06, 0);
    step(0, 0, 0, 0, 0, 1, 0, 8'h06, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sbn_result_model", ref_mem[8'h06], 32'hfffffffe);
    do_reset();
    step(1, 0, 8'h02, 0, 1, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 8'h07, 0, 0, 1, 0, 8'h08, 0);
    chk("core_first_after_reset", g_c, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (!rc_p && (rc_s != 0 || $urandom_range(2) != 0)) begin
        rc_p = 1;
        rc_a = 8'($urandom_range(15));
        rc_d = $urandom;
        if (rc_s == 0) begin
          rc_l = 1'($urandom_range(1));
          rc_w = rc_l ? 1'b0 : 1'($urandom_range(1));
          rc_s = rc_l ? 1 : 0;
        end else if (rc_s == 1) begin
          rc_l = 1; rc_w = 0; rc_s = 2;
        end else begin
          rc_l = 0; rc_w = 1; rc_s = 0;
        end
      end
      if (!rh_p && $urandom_range(1) != 0) begin
        rh_p = 1;
        rh_w = 1'($urandom_range(1));
        rh_a = 8'($urandom_range(15));
        rh_d = $urandom;
      end
      step(rc_p, rc_w, rc_a, rc_d, rc_l, rh_p, rh_w, rh_a, rh_d);
      if (g_c) rc_p = 0;
      if (g_h) rh_p = 0;
    end
`ifdef SBN_DMEM_ARB_STATS_EN
    do_reset();
    step(1, 0, 8'h01, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 0, 1, 0, 8'h09, 0);
    chk("stat_hstall_sat", stat_hstall, 16'hffff);
    chk("stat_cgnt_lock", stat_cgnt, 1);
    do_reset();
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain", cq.size() + hq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
